invaders_formation: RTL and testbench
=====================================

# invaders_formation

Drives the alien formation state consumed by the gameplay status monitor and the video renderer. It holds the 20-bit alive mask (`invaders_array`), the descent row (`invaders_line`) and the horizontal position (`invaders_x`), and it marches the formation on a programmable timebase. Player-shot hits clear alive bits. All motion freezes once `gameplay` leaves PLAYING.

## Interface
Parameters:
- `STEP_DIV`, 18_000_000: clocks per march step at normal speed (0.5 s at 36 MHz); range 4..2^25.
- `FAST_COUNT`, 5: when the alive count is ≤ this value, the step period becomes `STEP_DIV>>1`.
- `X_MIN`, 16: leftmost legal `invaders_x`.
- `X_MAX`, 400: rightmost legal `invaders_x`.
- `X_STEP`, 8: pixels moved per step.

Ports:
- `clk_36MHz`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-low. Clears all state immediately.
- `gameplay`, in, 2: status from the monitor. 00 = PLAYING, 01 = YOU_WIN, 10 = GAME_OVER.
- `hit_valid`, in, 1: single-cycle strobe from shot collision logic.
- `hit_index`, in, 5: index of the hit invader, 0..19.
- `invaders_array`, out, 20: alive mask; bit i = invader i alive.
- `invaders_line`, out, 4: descent row count.
- `invaders_x`, out, 10: formation left-edge x coordinate.
- `step_pulse`, out, 1: one-cycle pulse after each march step (drives the sound tick).
- `hit_ack`, out, 1: one-cycle pulse when a hit actually killed an invader.

## Operation
- Reset values:
  - `invaders_array` = 20'hFFFFF, `invaders_line` = 0, `invaders_x` = `X_MIN`.
  - Direction = right, step counter = 0.
  - `step_pulse` = 0, `hit_ack` = 0.
- Active state: all updates happen only while `gameplay` == 00. For any other value:
  - the counter holds;
  - no steps occur;
  - hits are ignored;
  - outputs hold;
  - pulses are 0.
- Period: `STEP_DIV` normally; `STEP_DIV>>1` when popcount(`invaders_array`) ≤ `FAST_COUNT`.
- Counter:
  - increments each active cycle;
  - when counter ≥ period−1, a step fires and the counter returns to 0;
  - the ≥ comparison covers the case where the period shrinks below the current count.
- Step, direction right:
  - if `invaders_x` + `X_STEP` > `X_MAX`: x is unchanged, direction flips to left, and `invaders_line` increments;
  - else x += `X_STEP`.
- Step, direction left:
  - if `invaders_x` < `X_MIN` + `X_STEP`: x is unchanged, direction flips to right, and `invaders_line` increments;
  - else x −= `X_STEP`.
- Line saturation: `invaders_line` saturates at 15; at 15 it never wraps to 0.
- Hits:
  - a hit counts when `hit_valid` is high, `hit_index` < 20 and the addressed bit is 1; that bit is cleared;
  - index ≥ 20 or an already-dead bit → no change and no `hit_ack`.
- Hit and step in the same cycle: both apply in that cycle. The period used for that step is the one computed from the pre-hit mask.
- Array empty (all zero): steps continue until the monitor reports YOU_WIN and the freeze takes effect.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- First step after reset release: `invaders_x` changes at the `STEP_DIV`-th active rising edge. `step_pulse` is high for exactly the cycle following that edge.
- Hit latency: the bit clears, and `hit_ack` rises, at the first rising edge where `hit_valid` is sampled high. `hit_ack` is high for exactly one cycle.
- Freeze latency:
  - the monitor registers its status one cycle after `invaders_line` reaches 3 or the array empties;
  - this block then freezes on the next edge;
  - at most one additional step can occur in that window. This is accepted.
- Reset mid-step or mid-hit: reset wins asynchronously, and every register returns to its reset value within the same cycle.

## Test plan
Bench parameters: `STEP_DIV`=4, `X_MIN`=0, `X_MAX`=16, `X_STEP`=8, `FAST_COUNT`=5.

- **March:** release reset with `gameplay`=00.
  - Expect `invaders_x` 0→8→16 at edges 4 and 8.
  - Expect `invaders_line`=1, x=16 and direction left at edge 12.
  - Expect x=8 at edge 16.
  - Expect `step_pulse` each time, one cycle wide.
- **Hit:** `hit_valid`=1 with `hit_index`=7.
  - Expect `invaders_array`=20'hFFF7F and `hit_ack`=1 for one cycle.
  - Repeat index 7 → no change and `hit_ack`=0.
  - Index 25 → no change.
- **Speed-up:** kill 15 invaders, leaving 5 alive.
  - Expect the step interval to drop from 4 to 2 cycles.
  - Switch with the counter at 3 → a step fires on the next edge.
- **Freeze:** set `gameplay`=10 mid-count.
  - Expect no x/line change and no pulses for 20 cycles.
  - A hit in this window is ignored.
  - Return to 00 → counting resumes from the held value.
- **Saturation:** run 40 edge reversals → `invaders_line` stays at 15.
- **Async reset:** assert `reset`=0 between clock edges after a hit.
  - Expect the array = FFFFF, line=0, x=0 and both pulses 0 immediately, without a clock edge.

Source files
------------

// File: rtl/invaders_formation.sv
// Alien formation state: alive mask, descent row and x position, marched on a
// programmable timebase while gameplay is PLAYING; shot hits clear alive bits.
module invaders_formation #(
    parameter int unsigned STEP_DIV   = 18_000_000,
    parameter int unsigned FAST_COUNT = 5,
    parameter int unsigned X_MIN      = 16,
    parameter int unsigned X_MAX      = 400,
    parameter int unsigned X_STEP     = 8
) (
    input  logic        clk_36MHz,
    input  logic        reset,
    input  logic [1:0]  gameplay,
    input  logic        hit_valid,
    input  logic [4:0]  hit_index,
    output logic [19:0] invaders_array,
    output logic [3:0]  invaders_line,
    output logic [9:0]  invaders_x,
    output logic        step_pulse,
    output logic        hit_ack
);

    localparam int unsigned CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST_SLOW  = CW'(STEP_DIV - 1);
    localparam logic [CW-1:0] LAST_FAST  = CW'((STEP_DIV >> 1) - 1);
    localparam logic [10:0]   X_MAX_W    = 11'(X_MAX);
    localparam logic [10:0]   X_STEP_W   = 11'(X_STEP);
    localparam logic [10:0]   X_LEFT_LIM = 11'(X_MIN + X_STEP);
    localparam logic [1:0]    PLAYING    = 2'b00;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

    dir_e          dir_q, dir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [19:0]   array_q, array_d;
    logic [3:0]    line_q, line_d;
    logic [9:0]    x_q, x_d;
    logic          step_q, step_d;
    logic          ack_q, ack_d;

    logic [4:0]    alive_cnt;
    logic [CW-1:0] last_cnt;
    logic [19:0]   hit_mask;
    logic          step_fire;
    logic          hit_ok;
    logic          at_edge;

    // Period is chosen from the pre-hit mask so a same-cycle hit cannot
    // shorten the step that is already being evaluated.
    always_comb begin
        alive_cnt = '0;
        for (int unsigned i = 0; i < 20; i++) begin
            alive_cnt = alive_cnt + 5'(array_q[i]);
        end
        last_cnt = (32'(alive_cnt) <= FAST_COUNT) ? LAST_FAST : LAST_SLOW;
    end

    always_comb begin
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        array_d   = array_q;
        line_d    = line_q;
        x_d       = x_q;
        step_d    = 1'b0;
        ack_d     = 1'b0;
        step_fire = 1'b0;
        at_edge   = 1'b0;
        hit_mask  = 20'(1) << hit_index;
        hit_ok    = hit_valid && (hit_index < 5'd20) && ((array_q & hit_mask) != '0);

        if (gameplay == PLAYING) begin
            // >= rather than == catches a period that shrank below the count.
            if (cnt_q >= last_cnt) begin
                cnt_d     = '0;
                step_fire = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end

            if (step_fire) begin
                step_d = 1'b1;
                unique case (dir_q)
                    DIR_RIGHT: begin
                        at_edge = ({1'b0, x_q} + X_STEP_W) > X_MAX_W;
                        if (at_edge) dir_d = DIR_LEFT;
                        else         x_d   = x_q + X_STEP_W[9:0];
                    end
                    DIR_LEFT: begin
                        at_edge = {1'b0, x_q} < X_LEFT_LIM;
                        if (at_edge) dir_d = DIR_RIGHT;
                        else         x_d   = x_q - X_STEP_W[9:0];
                    end
                    default: ;
                endcase
                if (at_edge && (line_q != 4'd15)) begin
                    line_d = line_q + 4'd1;
                end
            end

            if (hit_ok) begin
                array_d = array_q & ~hit_mask;
                ack_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_36MHz or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            dir_q   <= DIR_RIGHT;
            array_q <= '1;
            line_q  <= '0;
            x_q     <= 10'(X_MIN);
            step_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            array_q <= array_d;
            line_q  <= line_d;
            x_q     <= x_d;
            step_q  <= step_d;
            ack_q   <= ack_d;
        end
    end

    assign invaders_array = array_q;
    assign invaders_line  = line_q;
    assign invaders_x     = x_q;
    assign step_pulse     = step_q;
    assign hit_ack        = ack_q;

endmodule

// File: tb/tb_invaders_formation.sv
// Directed bench for invaders_formation with STEP_DIV=4, X 0..16 step 8,
// FAST_COUNT=5; outputs sampled 1 ns after each rising edge.
module tb_invaders_formation;

    logic        clk_36MHz;
    logic        reset;
    logic [1:0]  gameplay;
    logic        hit_valid;
    logic [4:0]  hit_index;
    logic [19:0] invaders_array;
    logic [3:0]  invaders_line;
    logic [9:0]  invaders_x;
    logic        step_pulse;
    logic        hit_ack;

    int unsigned tests;
    int unsigned fails;

    invaders_formation #(
        .STEP_DIV  (4),
        .FAST_COUNT(5),
        .X_MIN     (0),
        .X_MAX     (16),
        .X_STEP    (8)
    ) dut (
        .clk_36MHz     (clk_36MHz),
        .reset         (reset),
        .gameplay      (gameplay),
        .hit_valid     (hit_valid),
        .hit_index     (hit_index),
        .invaders_array(invaders_array),
        .invaders_line (invaders_line),
        .invaders_x    (invaders_x),
        .step_pulse    (step_pulse),
        .hit_ack       (hit_ack)
    );

    initial clk_36MHz = 1'b0;
    always #5 clk_36MHz = ~clk_36MHz;

    task automatic tick();
        @(posedge clk_36MHz);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        logic [9:0] march_x [4];
        logic [3:0] march_l [4];
        march_x = '{10'd8, 10'd16, 10'd16, 10'd8};
        march_l = '{4'd0, 4'd0, 4'd1, 4'd1};
        tests = 0;
        fails = 0;

        // Reset state
        reset     = 1'b0;
        gameplay  = 2'b00;
        hit_valid = 1'b0;
        hit_index = 5'd0;
        tick();
        tick();
        check("rst_array", 32'(invaders_array), 32'hFFFFF);
        check("rst_line",  32'(invaders_line),  32'd0);
        check("rst_x",     32'(invaders_x),     32'd0);
        check("rst_step",  32'(step_pulse),     32'd0);
        check("rst_ack",   32'(hit_ack),        32'd0);
        reset = 1'b1;

        // March: steps at edges 4, 8, 12, 16
        for (int s = 0; s < 4; s++) begin
            for (int e = 0; e < 3; e++) begin
                tick();
                check("march_nopulse", 32'(step_pulse), 32'd0);
            end
            tick();
            check("march_pulse", 32'(step_pulse),    32'd1);
            check("march_x",     32'(invaders_x),    32'(march_x[s]));
            check("march_line",  32'(invaders_line), 32'(march_l[s]));
        end

        // Hits (counter = 0 here)
        hit_valid = 1'b1;
        hit_index = 5'd7;
        tick();                                             // edge 17
        check("hit7_array", 32'(invaders_array), 32'hFFF7F);
        check("hit7_ack",   32'(hit_ack),        32'd1);
        hit_valid = 1'b0;
        tick();                                             // edge 18
        check("hit7_ack_one", 32'(hit_ack), 32'd0);
        hit_valid = 1'b1;
        tick();                                             // edge 19, dead bit 7
        check("dead_array", 32'(invaders_array), 32'hFFF7F);
        check("dead_ack",   32'(hit_ack),        32'd0);
        hit_index = 5'd25;
        tick();                                             // edge 20, step left to 0
        check("idx25_array", 32'(invaders_array), 32'hFFF7F);
        check("idx25_ack",   32'(hit_ack),        32'd0);
        check("idx25_x",     32'(invaders_x),     32'd0);
        check("idx25_step",  32'(step_pulse),     32'd1);
        hit_valid = 1'b0;

        // Speed-up: one idle edge, then kill 0..6 and 8..14 over edges 22..35
        tick();                                             // edge 21
        for (int i = 0; i < 15; i++) begin
            if (i != 7) begin
                hit_valid = 1'b1;
                hit_index = 5'(i);
                tick();
            end
        end
        hit_valid = 1'b0;
        check("kill_array", 32'(invaders_array), 32'hF8000);
        check("kill_ack",   32'(hit_ack),        32'd1);
        check("kill_x",     32'(invaders_x),     32'd16);
        check("kill_line",  32'(invaders_line),  32'd2);
        tick();                                             // edge 36, count 3 >= 1
        check("fast_sw_pulse", 32'(step_pulse),    32'd1);
        check("fast_sw_line",  32'(invaders_line), 32'd3);
        check("fast_sw_x",     32'(invaders_x),    32'd16);
        tick();
        check("fast_gap", 32'(step_pulse), 32'd0);
        tick();                                             // edge 38
        check("fast_pulse1", 32'(step_pulse), 32'd1);
        check("fast_x1",     32'(invaders_x), 32'd8);
        tick();
        check("fast_gap2", 32'(step_pulse), 32'd0);
        tick();                                             // edge 40
        check("fast_pulse2", 32'(step_pulse), 32'd1);
        check("fast_x2",     32'(invaders_x), 32'd0);
        tick();                                             // edge 41, count 1

        // Freeze with count held at 1
        gameplay = 2'b10;
        for (int i = 0; i < 20; i++) begin
            hit_valid = (i == 10);
            hit_index = 5'd15;
            tick();
            check("frz_pulse", 32'(step_pulse),    32'd0);
            check("frz_ack",   32'(hit_ack),       32'd0);
            check("frz_x",     32'(invaders_x),    32'd0);
            check("frz_line",  32'(invaders_line), 32'd3);
        end
        hit_valid = 1'b0;
        check("frz_array", 32'(invaders_array), 32'hF8000);
        gameplay = 2'b00;
        tick();                                             // held count 1 fires now
        check("resume_pulse", 32'(step_pulse),    32'd1);
        check("resume_line",  32'(invaders_line), 32'd4);
        check("resume_x",     32'(invaders_x),    32'd0);

        // Saturation: 40 reversals at 3 steps each, 2 cycles per step
        for (int i = 0; i < 240; i++) tick();
        check("sat_line", 32'(invaders_line), 32'd15);
        for (int i = 0; i < 6; i++) tick();
        check("sat_line_hold", 32'(invaders_line), 32'd15);

        // Async reset between edges right after a hit
        hit_valid = 1'b1;
        hit_index = 5'd16;
        tick();
        hit_valid = 1'b0;
        check("pre_rst_ack",   32'(hit_ack),        32'd1);
        check("pre_rst_array", 32'(invaders_array), 32'hE8000);
        #2;
        reset = 1'b0;
        #1;
        check("arst_array", 32'(invaders_array), 32'hFFFFF);
        check("arst_line",  32'(invaders_line),  32'd0);
        check("arst_x",     32'(invaders_x),     32'd0);
        check("arst_step",  32'(step_pulse),     32'd0);
        check("arst_ack",   32'(hit_ack),        32'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("post_rst_x0", 32'(invaders_x), 32'd0);
        tick();
        check("post_rst_x8", 32'(invaders_x), 32'd8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
